vga_timing_gen: RTL

//  - Raster timing source for the demoscene VGA path: produces hsync/vsync, hpos/vpos, visible.
//  - Feeds the pixel colour stage, which consumes hpos/vpos/visible and returns R/G/B.
//  - One pixel per clk (25.175 MHz nominal, 640x480@60 by default). All outputs registered, mutually aligned.

---
 rtl/vga_timing_gen.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing source for the VGA path.
//   Generates hpos/vpos counters and the hsync, vsync, visible, line_start
//   and frame_start flags, one pixel per clk. Every output is registered and
//   describes the same raster position in the same cycle.
//
// Ports:
//   clk          in   pixel clock
//   rst_n        in   synchronous active-low reset
//   hsync        out  horizontal sync, active level HSYNC_POL
//   vsync        out  vertical sync, active level VSYNC_POL
//   hpos         out  pixel column, 0..H_TOTAL-1
//   vpos         out  line, 0..V_TOTAL-1
//   visible      out  high inside the active H and V region
//   line_start   out  one-cycle pulse at hpos==0
//   frame_start  out  one-cycle pulse at hpos==0 && vpos==0
//   frame_cnt    out  frame counter (only with VGA_TIMING_FRAME_CNT_EN)
//
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN adds the frame_cnt port
// and register. Without it the port and register are absent.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int FRAME_W   = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       visible,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [FRAME_W-1:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Region boundaries as 10-bit counter values.
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FP_AT   = 10'(H_DISPLAY);
    localparam logic [9:0] H_SYN_AT  = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_BP_AT   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP_AT   = 10'(V_DISPLAY);
    localparam logic [9:0] V_SYN_AT  = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_BP_AT   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    // Elaboration-time parameter checks.
    if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_porch
        $error("vga_timing_gen: porch/sync parameters must be >= 1");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
    end

    typedef enum logic [1:0] {H_ACT, H_FP, H_SYN, H_BP} h_state_t;
    typedef enum logic [1:0] {V_ACT, V_FP, V_SYN, V_BP} v_state_t;

    h_state_t   h_state, h_state_nxt;
    v_state_t   v_state, v_state_nxt;
    logic [9:0] hpos_nxt, vpos_nxt;
    logic       h_wrap;

    // Next-state counters; the flags below are derived from these so that
    // they line up with the registered counters.
    always_comb begin
        h_wrap   = (hpos == H_LAST);
        hpos_nxt = h_wrap ? 10'd0 : 10'(hpos + 10'd1);
        vpos_nxt = vpos;
        if (h_wrap) begin
            vpos_nxt = (vpos == V_LAST) ? 10'd0 : 10'(vpos + 10'd1);
        end
    end

    // Horizontal region FSM, steps every pixel.
    always_comb begin
        h_state_nxt = h_state;
        case (h_state)
            H_ACT: if (hpos_nxt == H_FP_AT)  h_state_nxt = H_FP;
            H_FP:  if (hpos_nxt == H_SYN_AT) h_state_nxt = H_SYN;
            H_SYN: if (hpos_nxt == H_BP_AT)  h_state_nxt = H_BP;
            H_BP:  if (hpos_nxt == 10'd0)    h_state_nxt = H_ACT;
            default: h_state_nxt = H_ACT;
        endcase
    end

    // Vertical region FSM, steps only on a line wrap.
    always_comb begin
        v_state_nxt = v_state;
        if (h_wrap) begin
            case (v_state)
                V_ACT: if (vpos_nxt == V_FP_AT)  v_state_nxt = V_FP;
                V_FP:  if (vpos_nxt == V_SYN_AT) v_state_nxt = V_SYN;
                V_SYN: if (vpos_nxt == V_BP_AT)  v_state_nxt = V_BP;
                V_BP:  if (vpos_nxt == 10'd0)    v_state_nxt = V_ACT;
                default: v_state_nxt = V_ACT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_state <= H_ACT;
            v_state <= V_ACT;
        end else begin
            h_state <= h_state_nxt;
            v_state <= v_state_nxt;
        end
    end

    // Registered outputs. In reset visible is forced low even though the
    // counters sit at (0,0); that is what blanks pixel (0,0) of the first
    // frame after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hpos        <= 10'd0;
            vpos        <= 10'd0;
            visible     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
        end else begin
            hpos        <= hpos_nxt;
            vpos        <= vpos_nxt;
            visible     <= (h_state_nxt == H_ACT) && (v_state_nxt == V_ACT);
            line_start  <= (hpos_nxt == 10'd0);
            frame_start <= (hpos_nxt == 10'd0) && (vpos_nxt == 10'd0);
            hsync       <= (h_state_nxt == H_SYN) ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= (v_state_nxt == V_SYN) ? VSYNC_POL : ~VSYNC_POL;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Bumps on the same edge that raises frame_start, so the new count is
    // presented alongside the pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (hpos_nxt == 10'd0 && vpos_nxt == 10'd0) begin
            frame_cnt <= FRAME_W'(frame_cnt + 1'b1);
        end
    end
`else
    // Frame counter not built.
`endif

endmodule
